// File: rtl/uart_rx_fifo_engine_if.sv
// Bus between a UART receive engine and its consumer.
// Engine-bound: rx (serial pin), eight/pen/ohel/k (frame format and bit time), rd (pop strobe).
// Consumer-bound: rx_rdy, data, perr, ferr (show-ahead head entry), ovf (sticky), level, busy.
interface uart_rx_fifo_engine_if #(
    parameter int unsigned AW = 2
);
    localparam int unsigned KW = 19;

    logic          rx;
    logic          eight;
    logic          pen;
    logic          ohel;
    logic [KW-1:0] k;
    logic          rd;

    logic          rx_rdy;
    logic [7:0]    data;
    logic          perr;
    logic          ferr;
    logic          ovf;
    logic [AW:0]   level;
    logic          busy;

    // Driver / consumer side
    modport master (
        output rx, eight, pen, ohel, k, rd,
        input  rx_rdy, data, perr, ferr, ovf, level, busy
    );

    // Receive engine side
    modport slave (
        input  rx, eight, pen, ohel, k, rd,
        output rx_rdy, data, perr, ferr, ovf, level, busy
    );
endinterface

// File: rtl/uart_rx_fifo_engine.sv
// Serial-to-parallel UART receiver feeding a show-ahead receive FIFO.
// Ports: clk, rst_out (async, active-high), bus (slave modport of uart_rx_fifo_engine_if):
//   rx/eight/pen/ohel/k in, rd pop strobe in; rx_rdy/data/perr/ferr head entry out,
//   ovf sticky overflow out, level fill count out, busy receiver-active out.
module uart_rx_fifo_engine #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_out,
    uart_rx_fifo_engine_if.slave   bus
);

    localparam int unsigned KW  = 19;
    localparam int unsigned SRW = 10;
    localparam int unsigned BCW = 4;
    localparam int unsigned LW  = AW + 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        START    = 2'd1,
        RECV     = 2'd2,
        STOP_CHK = 2'd3
    } state_t;

    typedef struct packed {
        logic       perr;
        logic       ferr;
        logic [7:0] data;
    } entry_t;

    // ---------------- state ----------------
    state_t           state_q,  state_d;
    logic             rx_meta_q, rx_meta_d;
    logic             rxs_q,    rxs_d;
    logic [KW-1:0]    cyc_q,    cyc_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic [SRW-1:0]   sr_q,     sr_d;
    logic             eight_q,  eight_d;
    logic             pen_q,    pen_d;
    logic             ohel_q,   ohel_d;
    logic [KW-1:0]    k_q,      k_d;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [AW-1:0]    wptr_q,   wptr_d;
    logic [AW-1:0]    rptr_q,   rptr_d;
    logic [LW-1:0]    level_q,  level_d;
    logic             ovf_q,    ovf_d;
    logic             rx_rdy_q, rx_rdy_d;
    entry_t           head_q,   head_d;
    logic             busy_q,   busy_d;

    // ---------------- frame decode ----------------
    logic             push;
    logic [BCW-1:0]   nb;
    logic [BCW-1:0]   par_idx;
    logic [7:0]       data_bits;
    logic             par_bit;
    logic             stop_bit;
    logic             exp_par;
    entry_t           entry;
    logic [KW-1:0]    half_m1;
    logic [KW-1:0]    full_m1;

    // Bits after start: data (7/8) + optional parity + stop
    always_comb begin
        nb        = BCW'(8) + {{(BCW-1){1'b0}}, eight_q} + {{(BCW-1){1'b0}}, pen_q};
        par_idx   = BCW'(7) + {{(BCW-1){1'b0}}, eight_q};
        data_bits = eight_q ? sr_q[7:0] : {1'b0, sr_q[6:0]};
        par_bit   = sr_q[par_idx];
        stop_bit  = sr_q[nb - BCW'(1)];
        exp_par   = (^data_bits) ^ ohel_q;
        entry.data = data_bits;
        entry.perr = pen_q & (par_bit != exp_par);
        entry.ferr = ~stop_bit;
        half_m1   = (k_q >> 1) - KW'(1);
        full_m1   = k_q - KW'(1);
    end

    // Receive FSM next-state; frame parameters are latched at start detect
    always_comb begin
        state_d   = state_q;
        rx_meta_d = bus.rx;
        rxs_d     = rx_meta_q;
        cyc_d     = cyc_q;
        bitcnt_d  = bitcnt_q;
        sr_d      = sr_q;
        eight_d   = eight_q;
        pen_d     = pen_q;
        ohel_d    = ohel_q;
        k_d       = k_q;
        push      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d  = START;
                    cyc_d    = '0;
                    bitcnt_d = '0;
                    sr_d     = '0;
                    eight_d  = bus.eight;
                    pen_d    = bus.pen;
                    ohel_d   = bus.ohel;
                    k_d      = bus.k;
                end
            end
            START: begin
                // Mid start bit: a high line here means a glitch, not a frame
                if (cyc_q == half_m1) begin
                    cyc_d = '0;
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    cyc_d = cyc_q + KW'(1);
                end
            end
            RECV: begin
                // One full bit time from the previous mid-bit lands on the next mid-bit
                if (cyc_q == full_m1) begin
                    cyc_d          = '0;
                    sr_d[bitcnt_q] = rxs_q;
                    bitcnt_d       = bitcnt_q + BCW'(1);
                    if (bitcnt_q == nb - BCW'(1)) begin
                        state_d = STOP_CHK;
                    end
                end else begin
                    cyc_d = cyc_q + KW'(1);
                end
            end
            STOP_CHK: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // FIFO update and registered show-ahead head
    logic pop;
    logic full;
    logic push_ok;
    logic overflow;

    always_comb begin
        mem_d    = mem_q;
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        push_ok  = 1'b0;
        overflow = 1'b0;

        pop  = bus.rd && (level_q != '0);
        full = (level_q == LW'(DEPTH));

        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end

        // When full, a same-cycle pop frees the slot the push lands in
        if (push) begin
            if (!full || pop) begin
                push_ok        = 1'b1;
                mem_d[wptr_q]  = entry;
                wptr_d         = wptr_q + AW'(1);
            end else begin
                overflow = 1'b1;
            end
        end

        case ({push_ok, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        if (overflow) begin
            ovf_d = 1'b1;
        end else if (bus.rd) begin
            ovf_d = 1'b0;
        end

        rx_rdy_d = (level_d != '0);
        head_d   = rx_rdy_d ? mem_d[rptr_d] : '0;
    end

    // State registers
    always_ff @(posedge clk or posedge rst_out) begin
        if (rst_out) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            cyc_q     <= '0;
            bitcnt_q  <= '0;
            sr_q      <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            k_q       <= '0;
            mem_q     <= '{default: '0};
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            rx_rdy_q  <= 1'b0;
            head_q    <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rxs_q     <= rxs_d;
            cyc_q     <= cyc_d;
            bitcnt_q  <= bitcnt_d;
            sr_q      <= sr_d;
            eight_q   <= eight_d;
            pen_q     <= pen_d;
            ohel_q    <= ohel_d;
            k_q       <= k_d;
            mem_q     <= mem_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            rx_rdy_q  <= rx_rdy_d;
            head_q    <= head_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.rx_rdy = rx_rdy_q;
    assign bus.data   = head_q.data;
    assign bus.perr   = head_q.perr;
    assign bus.ferr   = head_q.ferr;
    assign bus.ovf    = ovf_q;
    assign bus.level  = level_q;
    assign bus.busy   = busy_q;

endmodule
